// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and default timing constants for the alarm ringer
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } ring_state_t;

    localparam int SNOOZE_CNT_W = 2;

    // Board-level defaults; the board top passes these unless overridden
    localparam int DEF_RING_TIMEOUT_S = 60;
    localparam int DEF_SNOOZE_S       = 300;
    localparam int DEF_MAX_SNOOZES    = 3;

    // Seconds counter width covering the longer of the two periods
    function automatic int sec_cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ring_timer.sv
// rtl/ring_timer.sv - tick-enabled seconds counter with clear, terminal compare and done pulse
module ring_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         tick_i,
    input  logic [W-1:0] term_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // done fires on the tick that completes the period; clear always wins
    assign done_o = !clear_i && tick_i && (cnt_q == term_i);

    // Count ticks; wrap to zero on the terminal tick so the next period starts clean
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == term_i) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm episode FSM (ring/snooze/dismiss/timeout); ALRM_MISSED_EN enables the missed flag
module alarm_ringer
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
    parameter int SNOOZE_S       = DEF_SNOOZE_S,
    parameter int MAX_SNOOZES    = DEF_MAX_SNOOZES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick_1hz,
    input  logic                    alrm_match,
    input  logic                    arm,
    input  logic                    snooze,
    input  logic                    dismiss,
    output logic                    ring,
    output logic                    ring_led,
    output logic                    snoozing,
    output logic [SNOOZE_CNT_W-1:0] snooze_cnt,
    output logic                    missed
);

    localparam int SEC_W = sec_cnt_width(RING_TIMEOUT_S, SNOOZE_S);
    localparam logic [SNOOZE_CNT_W-1:0] MAX_SN    = SNOOZE_CNT_W'(MAX_SNOOZES);
    localparam logic [SNOOZE_CNT_W-1:0] SN_ONE    = SNOOZE_CNT_W'(1);
    localparam logic [SEC_W-1:0]        RING_TERM = SEC_W'(RING_TIMEOUT_S - 1);
    localparam logic [SEC_W-1:0]        SNZ_TERM  = SEC_W'(SNOOZE_S - 1);

    // The snooze count must fit the output port
    if (MAX_SNOOZES > (1 << SNOOZE_CNT_W) - 1) begin : g_max_snoozes_chk
        $error("alarm_ringer: MAX_SNOOZES does not fit snooze_cnt");
    end

    ring_state_t             state_q;
    ring_state_t             state_d;
    logic                    match_q;
    logic [SNOOZE_CNT_W-1:0] snz_cnt_q;
    logic [SNOOZE_CNT_W-1:0] snz_cnt_d;
    logic                    blink_q;
    logic                    blink_d;
    logic                    ring_q;
    logic                    snoozing_q;

    logic                    trigger;
    logic                    snooze_take;
    logic                    t_clear;
    logic                    t_tick;
    logic                    t_done;
    logic [SEC_W-1:0]        t_term;

`ifdef ALRM_MISSED_EN
    logic                    missed_q;
    logic                    missed_d;
`endif

    assign trigger     = alrm_match && !match_q;
    assign snooze_take = (state_q == RINGING) && snooze && (snz_cnt_q < MAX_SN);

    // The timer idles cleared, restarts on snooze entry, and only sees ticks
    // that no higher-priority event in the same cycle has consumed
    assign t_clear = (state_q == IDLE) || snooze_take;
    assign t_tick  = tick_1hz && arm && !dismiss && (state_q != IDLE) && !snooze_take;
    assign t_term  = (state_q == RINGING) ? RING_TERM : SNZ_TERM;

    ring_timer #(
        .W (SEC_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (t_clear),
        .tick_i  (t_tick),
        .term_i  (t_term),
        .done_o  (t_done)
    );

    // Next-state logic in priority order: !arm, dismiss, snooze, tick, trigger
    always_comb begin
        state_d   = state_q;
        snz_cnt_d = snz_cnt_q;
        blink_d   = blink_q;
`ifdef ALRM_MISSED_EN
        missed_d  = missed_q;
`endif
        case (state_q)
            IDLE: begin
                if (arm) begin
                    if (dismiss) begin
`ifdef ALRM_MISSED_EN
                        missed_d = 1'b0;
`endif
                    end else if (trigger) begin
                        state_d   = RINGING;
                        snz_cnt_d = '0;
                        blink_d   = 1'b1;
`ifdef ALRM_MISSED_EN
                        missed_d  = 1'b0;
`endif
                    end
                end
            end
            RINGING: begin
                if (!arm || dismiss) begin
                    state_d = IDLE;
                end else if (snooze_take) begin
                    state_d   = SNOOZE;
                    snz_cnt_d = snz_cnt_q + SN_ONE;
                end else if (t_tick) begin
                    blink_d = !blink_q;
                    if (t_done) begin
                        state_d = IDLE;
`ifdef ALRM_MISSED_EN
                        missed_d = 1'b1;
`endif
                    end
                end
            end
            SNOOZE: begin
                if (!arm || dismiss) begin
                    state_d = IDLE;
                end else if (t_done) begin
                    state_d = RINGING;
                    blink_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, edge detector and registered state-decode outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            match_q    <= 1'b0;
            snz_cnt_q  <= '0;
            blink_q    <= 1'b1;
            ring_q     <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            match_q    <= alrm_match;
            snz_cnt_q  <= snz_cnt_d;
            blink_q    <= blink_d;
            ring_q     <= (state_d == RINGING);
            snoozing_q <= (state_d == SNOOZE);
        end
    end

`ifdef ALRM_MISSED_EN
    // Sticky flag: last episode ended by timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            missed_q <= 1'b0;
        end else begin
            missed_q <= missed_d;
        end
    end

    assign missed = missed_q;
`else
    assign missed = 1'b0;
`endif

    assign ring       = ring_q;
    assign ring_led   = ring_q & blink_q;
    assign snoozing   = snoozing_q;
    assign snooze_cnt = snz_cnt_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// tb/tb_alarm_ringer.sv - self-checking bench for alarm_ringer with an episode-level model
module tb_alarm_ringer;

    localparam int R = 4;
    localparam int S = 3;
    localparam int M = 2;
`ifdef ALRM_MISSED_EN
    localparam int MEN = 1;
`else
    localparam int MEN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       match = 1'b0;
    logic       arm = 1'b0;
    logic       snz = 1'b0;
    logic       dis = 1'b0;
    logic       w_ring;
    logic       w_led;
    logic       w_snoozing;
    logic [1:0] w_cnt;
    logic       w_missed;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Episode model
    bit m_ring, m_snz, m_blink, m_missed, m_prev;
    int m_elapsed, m_snoozes;

    alarm_ringer #(
        .RING_TIMEOUT_S (R),
        .SNOOZE_S       (S),
        .MAX_SNOOZES    (M)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .tick_1hz   (tick),
        .alrm_match (match),
        .arm        (arm),
        .snooze     (snz),
        .dismiss    (dis),
        .ring       (w_ring),
        .ring_led   (w_led),
        .snoozing   (w_snoozing),
        .snooze_cnt (w_cnt),
        .missed     (w_missed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit trig;
        if (!rst_n) begin
            m_ring = 0; m_snz = 0; m_blink = 1; m_missed = 0; m_prev = 0;
            m_elapsed = 0; m_snoozes = 0;
        end else begin
            trig   = match && !m_prev;
            m_prev = match;
            if (m_ring) begin
                if (!arm || dis) begin
                    m_ring = 0;
                end else if (snz && m_snoozes < M) begin
                    m_ring = 0; m_snz = 1; m_snoozes++; m_elapsed = 0;
                end else if (tick) begin
                    m_blink = !m_blink;
                    m_elapsed++;
                    if (m_elapsed == R) begin
                        m_ring = 0; m_elapsed = 0; m_missed = (MEN != 0);
                    end
                end
            end else if (m_snz) begin
                if (!arm || dis) begin
                    m_snz = 0;
                end else if (tick) begin
                    m_elapsed++;
                    if (m_elapsed == S) begin
                        m_snz = 0; m_ring = 1; m_elapsed = 0; m_blink = 1;
                    end
                end
            end else if (arm) begin
                if (dis) begin
                    m_missed = 0;
                end else if (trig) begin
                    m_ring = 1; m_elapsed = 0; m_snoozes = 0; m_blink = 1; m_missed = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model ring", w_ring, m_ring);
            chk("model ring_led", w_led, m_ring & m_blink);
            chk("model snoozing", w_snoozing, m_snz);
            chk("model snooze_cnt", w_cnt, m_snoozes);
            chk("model missed", w_missed, m_missed);
        end
    end

    task automatic cyc(input bit t, input bit s, input bit d);
        tick = t; snz = s; dis = d;
        @(posedge clk);
        #1;
        tick = 0; snz = 0; dis = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 0);
            cyc(0, 0, 0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset ring", w_ring, 0);
        chk("reset ring_led", w_led, 0);
        chk("reset snoozing", w_snoozing, 0);
        chk("reset snooze_cnt", w_cnt, 0);
        chk("reset missed", w_missed, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        cyc(0, 0, 0);

        // 1: trigger, held level, blink per tick
        arm = 1'b1;
        cyc(0, 0, 0);
        match = 1'b1;
        cyc(0, 0, 0);
        chk("t1 ring on trigger", w_ring, 1);
        chk("t1 led initial", w_led, 1);
        cyc(1, 0, 0);
        chk("t1 led after tick1", w_led, 0);
        cyc(1, 0, 0);
        chk("t1 led after tick2", w_led, 1);
        cyc(1, 0, 0);
        chk("t1 ring held", w_ring, 1);
        cyc(0, 0, 1);
        chk("t1 dismiss", w_ring, 0);
        match = 1'b0;
        cyc(0, 0, 0);

        // 2: timeout then retrigger
        match = 1'b1;
        cyc(0, 0, 0);
        ticks(R - 1);
        chk("t2 ring before timeout", w_ring, 1);
        cyc(1, 0, 0);
        chk("t2 ring after timeout", w_ring, 0);
        chk("t2 missed", w_missed, MEN);
        cyc(0, 0, 0);
        chk("t2 held no retrigger", w_ring, 0);
        match = 1'b0;
        cyc(0, 0, 0);
        match = 1'b1;
        cyc(0, 0, 0);
        chk("t2 retrigger", w_ring, 1);
        chk("t2 missed cleared", w_missed, 0);

        // 3: snooze twice, third ignored
        cyc(0, 1, 0);
        chk("t3 snoozing", w_snoozing, 1);
        chk("t3 cnt1", w_cnt, 1);
        ticks(S - 1);
        chk("t3 still snoozing", w_snoozing, 1);
        cyc(1, 0, 0);
        chk("t3 rings again", w_ring, 1);
        cyc(0, 1, 0);
        chk("t3 cnt2", w_cnt, 2);
        ticks(S);
        chk("t3 rings after 2nd", w_ring, 1);
        cyc(0, 1, 0);
        chk("t3 third ignored ring", w_ring, 1);
        chk("t3 third ignored cnt", w_cnt, 2);

        // 4: snooze and tick in the same cycle
        cyc(0, 0, 1);
        match = 1'b0;
        cyc(0, 0, 0);
        match = 1'b1;
        cyc(0, 0, 0);
        cyc(1, 1, 0);
        chk("t4 snoozing", w_snoozing, 1);
        ticks(S - 1);
        chk("t4 not early", w_snoozing, 1);
        cyc(1, 0, 0);
        chk("t4 ring resumes", w_ring, 1);

        // 5: disarm, trigger coincident with arm rising, dismiss from snooze
        arm = 1'b0;
        cyc(0, 0, 0);
        chk("t5 disarm", w_ring, 0);
        match = 1'b0;
        cyc(0, 0, 0);
        arm   = 1'b1;
        match = 1'b1;
        cyc(0, 0, 0);
        chk("t5 arm+trigger", w_ring, 1);
        chk("t5 cnt reset", w_cnt, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        chk("t5 dismiss snoozing", w_snoozing, 0);
        chk("t5 dismiss ring", w_ring, 0);

        // 6: async reset mid-snooze, then a clean episode with timeout
        match = 1'b0;
        cyc(0, 0, 0);
        match = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async snoozing", w_snoozing, 0);
        chk("t6 async cnt", w_cnt, 0);
        chk("t6 async ring", w_ring, 0);
        match = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0);
        match = 1'b1;
        cyc(0, 0, 0);
        chk("t6 ring after reset", w_ring, 1);
        chk("t6 cnt after reset", w_cnt, 0);
        ticks(R);
        chk("t6 timeout ring", w_ring, 0);
        chk("t6 timeout missed", w_missed, MEN);
        cyc(0, 0, 0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
